addsub_chunked_pipelined: RTL

// Parametrised pipelined adder/subtractor for retiming experiments. Operands are

---
 rtl/addsub_chunked_pipelined_if.sv | 29 ++
 rtl/addsub_chunked_pipelined.sv | 112 +++++++++++
 2 files changed

// File: rtl/addsub_chunked_pipelined_if.sv
// Handshake and data bundle for the chunked pipelined adder/subtractor.
// The master drives operands and the downstream ready. The slave (the adder)
// drives the result and both handshake responses.
interface addsub_chunked_pipelined_if #(
  parameter int DATAWIDTH = 16
);
  logic [DATAWIDTH-1:0] A;
  logic [DATAWIDTH-1:0] B;
  logic [1:0]           op;
  logic                 cin;
  logic                 sat;
  logic                 i_valid;
  logic                 i_ready;
  logic [DATAWIDTH-1:0] Result;
  logic                 carry_borrow;
  logic                 overflow;
  logic                 o_valid;
  logic                 o_ready;

  modport master (
    output A, B, op, cin, sat, i_valid, o_ready,
    input  i_ready, Result, carry_borrow, overflow, o_valid
  );

  modport slave (
    input  A, B, op, cin, sat, i_valid, o_ready,
    output i_ready, Result, carry_borrow, overflow, o_valid
  );
endinterface

// File: rtl/addsub_chunked_pipelined.sv
// Pipelined adder/subtractor with operands sliced into CHUNK_WIDTH-bit chunks.
// Position k (0..NUM_CHUNKS-1) holds an optional register followed by the ripple
// adder for chunk k. Position NUM_CHUNKS holds an optional output register. The
// first NUM_PIPELINE_STAGES positions are registered. Operands, the carry, sat
// and valid travel together with the partial sum. One global advance signal
// stalls or shifts every stage at once.
module addsub_chunked_pipelined #(
  parameter int DATAWIDTH           = 16,
  parameter int CHUNK_WIDTH         = 4,
  parameter int NUM_PIPELINE_STAGES = 5,
  parameter int INSTANCE_ID         = 0
) (
  input logic                       clk,
  input logic                       rst,
  addsub_chunked_pipelined_if.slave bus
);

  localparam int NUM_CHUNKS = (CHUNK_WIDTH > 0) ? DATAWIDTH / CHUNK_WIDTH : 1;
  localparam int NUM_REGS   = NUM_CHUNKS + 1;
  localparam int MSB        = DATAWIDTH - 1;

  localparam logic [DATAWIDTH-1:0] SAT_POS = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic [DATAWIDTH-1:0] SAT_NEG = {1'b1, {(DATAWIDTH-1){1'b0}}};

  if (CHUNK_WIDTH < 1) begin : g_bad_chunk
    $error("CHUNK_WIDTH must be at least 1");
  end else if (DATAWIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("DATAWIDTH must be a multiple of CHUNK_WIDTH");
  end
  if (NUM_PIPELINE_STAGES < 0 || NUM_PIPELINE_STAGES > NUM_REGS) begin : g_bad_stages
    $error("NUM_PIPELINE_STAGES must lie in 0..NUM_CHUNKS+1");
  end
  if (INSTANCE_ID < 0) begin : g_bad_id
    $error("INSTANCE_ID must be non-negative");
  end

  // b is stored already conditionally inverted. sum holds the chunks finished
  // so far. carry is the carry into the next chunk to be added.
  typedef struct packed {
    logic                 valid;
    logic                 sat;
    logic                 carry;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] sum;
  } stage_t;

  // Ripple-add one chunk and pass the carry on to the next chunk.
  function automatic stage_t chunk_step(input stage_t s, input int idx);
    stage_t           r;
    logic [CHUNK_WIDTH:0] t;
    r = s;
    t = {1'b0, s.a[idx*CHUNK_WIDTH +: CHUNK_WIDTH]}
      + {1'b0, s.b[idx*CHUNK_WIDTH +: CHUNK_WIDTH]}
      + {{CHUNK_WIDTH{1'b0}}, s.carry};
    r.sum[idx*CHUNK_WIDTH +: CHUNK_WIDTH] = t[CHUNK_WIDTH-1:0];
    r.carry = t[CHUNK_WIDTH];
    return r;
  endfunction

  stage_t in_s;
  stage_t pipe_s;
  stage_t stage_d [NUM_REGS];
  stage_t stage_q [NUM_REGS];
  logic   advance;
  logic   ovf;

  assign in_s = '{
    valid: bus.i_valid,
    sat:   bus.sat,
    carry: bus.op[1] ? bus.cin : bus.op[0],
    a:     bus.A,
    b:     bus.B ^ {DATAWIDTH{bus.op[0]}},
    sum:   '0
  };

  // Walk the positions. Registered positions take the register output, and
  // unregistered positions pass the value straight through.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can leave a latch behind.
    pipe_s = in_s;
    for (int k = 0; k < NUM_REGS; k++) begin
      stage_d[k] = pipe_s;
      if (k < NUM_PIPELINE_STAGES) pipe_s = stage_q[k];
      if (k < NUM_CHUNKS) pipe_s = chunk_step(pipe_s, k);
    end
  end

  // Shift or hold all stages together. Reset clears both the data and the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared too so Result/flags read zero right after reset.
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) stage_q[k] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      for (int k = 0; k < NUM_REGS; k++) stage_q[k] <= stage_d[k];
    end
  end

  // Overflow is taken from the unsaturated sum. Saturation never alters the carry.
  assign ovf = (pipe_s.a[MSB] == pipe_s.b[MSB]) && (pipe_s.sum[MSB] != pipe_s.a[MSB]);

  assign bus.o_valid      = pipe_s.valid;
  assign bus.carry_borrow = pipe_s.carry;
  assign bus.overflow     = ovf;
  assign bus.Result       = (pipe_s.sat && ovf) ? (pipe_s.a[MSB] ? SAT_NEG : SAT_POS)
                                                : pipe_s.sum;

  assign advance     = !pipe_s.valid || bus.o_ready;
  assign bus.i_ready = (NUM_PIPELINE_STAGES == 0) ? bus.o_ready : advance;

endmodule
